// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous 512Kx16 SRAM controller.
//   SRAM_ADDR_W     : word address width of the SRAM (19)
//   SRAM_DATA_W     : data bus width of the SRAM (16)
//   MAX_WAIT_CYCLES : largest legal WAIT_CYCLES value of sram_ctrl
//   sram_state_e    : controller FSM state encoding; ST_TURN exists only
//                     when SRAM_CTRL_TURNAROUND_EN is defined
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W     = 19;
  localparam int SRAM_DATA_W     = 16;
  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3
`ifdef SRAM_CTRL_TURNAROUND_EN
    ,
    ST_TURN   = 3'd4
`endif
  } sram_state_e;

endpackage

// File: rtl/sram_dat_io.sv
// Tristate pad for the SRAM data bus. Kept separate so a technology
// specific IO primitive can replace the behavioural buffer.
//   oe   : 1 = drive dout onto the pad, 0 = pad high-Z
//   dout : data driven while oe = 1
//   din  : current pad value, captured by the controller
//   pad  : bidirectional SRAM data pins
module sram_dat_io
  import sram_ctrl_pkg::*;
(
  input  logic                   oe,
  input  logic [SRAM_DATA_W-1:0] dout,
  output logic [SRAM_DATA_W-1:0] din,
  inout  wire  [SRAM_DATA_W-1:0] pad
);

  assign pad = oe ? dout : {SRAM_DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port controller for the asynchronous 512Kx16 SRAM. Converts a
// valid/ready request stream (one 16-bit read or write per request) into
// SETUP / ACCESS / HOLD strobe sequences and returns read data with a
// one-cycle rsp_valid pulse. Every pin and handshake output is a flop.
//
// Parameter WAIT_CYCLES (0..15): extra ACCESS cycles; strobe-active width
// is WAIT_CYCLES+1 clocks.
// Optional feature macro SRAM_CTRL_TURNAROUND_EN: after a write's HOLD,
// spend one TURN cycle with all strobes high and the bus released.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata : request fields, latched on acceptance
//   rsp_valid, rsp_rdata    : read-completion pulse, read data (held)
//   ADR, DAT                : SRAM address, bidirectional data bus
//   RAMCS, RAMOE, RAMWE     : active-low chip select / output / write enable
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [SRAM_ADDR_W-1:0] req_addr,
  input  logic [SRAM_DATA_W-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [SRAM_DATA_W-1:0] rsp_rdata,
  output logic [SRAM_ADDR_W-1:0] ADR,
  inout  wire  [SRAM_DATA_W-1:0] DAT,
  output logic                   RAMCS,
  output logic                   RAMOE,
  output logic                   RAMWE
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYCLES out of range 0..15");
  end

  sram_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [SRAM_ADDR_W-1:0] adr_q, adr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic                   cs_q, cs_d;
  logic                   oe_q, oe_d;
  logic                   we_q, we_d;
  logic                   dat_oe_q, dat_oe_d;
  logic                   ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [SRAM_DATA_W-1:0] din;

  sram_dat_io u_dat_io (
    .oe   (dat_oe_q),
    .dout (wdata_q),
    .din  (din),
    .pad  (DAT)
  );

  // The strobe values computed here belong to the state being entered, so
  // the registered pins line up with the registered state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cs_d        = 1'b1;
    oe_d        = 1'b1;
    we_d        = 1'b1;
    dat_oe_d    = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          state_d  = ST_SETUP;
          is_wr_d  = req_we;
          adr_d    = req_addr;
          wdata_d  = req_wdata;
          ready_d  = 1'b0;
          cs_d     = 1'b0;
          oe_d     = req_we;
          dat_oe_d = req_we;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        cnt_d    = CNT_W'(WAIT_CYCLES);
        cs_d     = 1'b0;
        we_d     = ~is_wr_q;
        oe_d     = is_wr_q;
        dat_oe_d = is_wr_q;
      end
      ST_ACCESS: begin
        cs_d     = 1'b0;
        dat_oe_d = is_wr_q;
        if (cnt_q == '0) begin
          // Closing edge of the last ACCESS cycle: read data is sampled
          // while RAMOE is still low, then strobes release in HOLD.
          state_d     = ST_HOLD;
          rsp_valid_d = ~is_wr_q;
          if (!is_wr_q) begin
            rdata_d = din;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          we_d  = ~is_wr_q;
          oe_d  = is_wr_q;
        end
      end
      ST_HOLD: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
        if (is_wr_q) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
`else
        state_d = ST_IDLE;
        ready_d = 1'b1;
`endif
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      ST_TURN: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      adr_q       <= '0;
      rdata_q     <= '0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      dat_oe_q    <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      adr_q       <= adr_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      dat_oe_q    <= dat_oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Write data is only observable while dat_oe_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ADR       = adr_q;
  assign RAMCS     = cs_q;
  assign RAMOE     = oe_q;
  assign RAMWE     = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: behavioural async SRAM on the pins, transaction
// level reference memory, response scoreboard and per-cycle pin monitor.
// WAIT may be overridden to exercise other ACCESS widths.
module tb_sram_ctrl;

  parameter int WAIT = 1;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [18:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [18:0] ADR;
  wire  [15:0] DAT;
  logic        RAMCS, RAMOE, RAMWE;

  sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ADR(ADR), .DAT(DAT),
    .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int failed   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- asynchronous SRAM pin model ----------------
  logic [15:0] mem [0:524287];
  logic [15:0] sram_q;
  logic        sram_drv;
  assign sram_drv = !RAMCS && !RAMOE && RAMWE;
  assign sram_q   = mem[ADR];
  assign DAT      = sram_drv ? sram_q : 16'hzzzz;

  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = 16'(i) ^ 16'hC3A5;
    forever begin
      @(negedge clk);
      if (!RAMCS && !RAMWE) mem[ADR] = DAT;
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [logic [18:0]];

  function automatic logic [15:0] ref_read(input logic [18:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 16'(a) ^ 16'hC3A5;
  endfunction

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  // current transaction as seen by the pin monitor
  logic        cur_we    = 1'b0;
  logic [18:0] cur_addr  = '0;
  logic [15:0] cur_wdata = '0;
  int unsigned busy_until = 0;

  // ---------------- response scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        compared++; failed++;
        $display("FAIL rsp_missing: no rsp_valid by cyc %0d, required at cyc %0d", cyc, exp_q[0].cyc);
        e = exp_q.pop_front();
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          compared++; failed++;
          $display("FAIL rsp_unexpected @cyc %0d: rsp_valid=1 rdata=0x%0h, required no response", cyc, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_rdata", rsp_rdata, e.data);
        end
      end
    end
  end

  // ---------------- pin monitor ----------------
  initial begin
    int cs_run = 0, we_run = 0, oe_run = 0;
    forever begin
      @(posedge clk); #1;
      chk("req_ready", req_ready, (cyc >= busy_until));
      chk("oe_vs_drive", (!RAMOE && dut.u_dat_io.oe), 0);
      if (rst) begin
        cs_run = 0; we_run = 0; oe_run = 0;
      end else begin
        if (!RAMCS) begin
          cs_run++;
          chk("adr_stable", ADR, cur_addr);
          chk("dat_drive", dut.u_dat_io.oe, cur_we);
          if (cur_we) begin
            chk("dat_stable", DAT, cur_wdata);
            chk("oe_in_write", RAMOE, 1);
          end else begin
            chk("we_in_read", RAMWE, 1);
          end
        end else begin
          if (cs_run != 0) begin chk("cs_width", cs_run, WAIT + 3); cs_run = 0; end
          chk("idle_strobes", {RAMOE, RAMWE, dut.u_dat_io.oe}, 3'b110);
        end
        if (!RAMWE) we_run++;
        else if (we_run != 0) begin chk("we_width", we_run, WAIT + 1); we_run = 0; end
        if (!RAMOE) oe_run++;
        else if (oe_run != 0) begin chk("oe_width", oe_run, WAIT + 2); oe_run = 0; end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_req(input logic we, input logic [18:0] addr, input logic [15:0] data,
                        output int unsigned acc);
    int n = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    acc = cyc;
    if (!req_ready) begin
      compared++; failed++;
      $display("FAIL req_accept_timeout: req_ready=0 after %0d cycles, required 1", n);
      req_valid = 1'b0;
      return;
    end
    cur_we = we; cur_addr = addr; cur_wdata = data;
    busy_until = cyc + 4 + WAIT + ((we && TURN != 0) ? 1 : 0);
    if (we) ref_mem[addr] = data;
    else begin
      e.cyc = cyc + 3 + WAIT; e.data = ref_read(addr);
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 19'($urandom);
      req_wdata = 16'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(output int unsigned c);
    int n = 0;
    req_valid = 1'b0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    c = cyc;
  endtask

  logic [18:0] pool [8] = '{19'h00000, 19'h7FFFF, 19'h12345, 19'h00001,
                            19'h40000, 19'h3FFFF, 19'h2AAAA, 19'h55555};

  initial begin
    int unsigned acc, acc2, c;
    exp_t e;
    // reset for 3 cycles with a request presented (must be ignored)
    req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h11111; req_wdata = 16'h1111;
    repeat (3) @(negedge clk);
    chk("rst_ramcs", RAMCS, 1);
    chk("rst_ramoe", RAMOE, 1);
    chk("rst_ramwe", RAMWE, 1);
    chk("rst_dat_drive", dut.u_dat_io.oe, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_adr", ADR, 0);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_cs", RAMCS, 1);

    // write 0x12345 = 0xBEEF, then measure ready return
    do_req(1'b1, 19'h12345, 16'hBEEF, acc);
    wait_ready(c);
    chk("wr_ready_gap", c - acc, 4 + WAIT + TURN);
    idle(2);

    // read it back
    do_req(1'b0, 19'h12345, 16'h0000, acc);
    wait_ready(c);
    chk("rd_ready_gap", c - acc, 4 + WAIT);
    idle(2);

    // write then read with req_valid held high throughout
    do_req(1'b1, 19'h00000, 16'hA5A5, acc);
    do_req(1'b0, 19'h7FFFF, 16'h0000, acc2);
    chk("b2b_accept_gap", acc2 - acc, 4 + WAIT + TURN);
    do_req(1'b0, 19'h00000, 16'h0000, acc);
    chk("b2b_rd_accept_gap", acc - acc2, 4 + WAIT);
    idle(WAIT + 6);

    // reset in the second ACCESS cycle of a read
    do_req(1'b0, 19'h2AAAA, 16'h0000, acc);
    req_valid = 1'b0;
    while (cyc < acc + ((WAIT == 0) ? 2 : 3)) @(negedge clk);
    rst = 1'b1; busy_until = 0;
    if (exp_q.size() != 0) e = exp_q.pop_back();
    @(negedge clk);
    chk("midrst_ramcs", RAMCS, 1);
    chk("midrst_ramoe", RAMOE, 1);
    chk("midrst_ramwe", RAMWE, 1);
    chk("midrst_dat_drive", dut.u_dat_io.oe, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    chk("midrst_ready", req_ready, 1);
    rst = 1'b0;
    c = cyc;
    do_req(1'b0, 19'h12345, 16'h0000, acc);
    chk("accept_after_rst", acc, c);
    idle(WAIT + 6);

    // randomized traffic, valid often held back-to-back
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [18:0] a;
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 19'($urandom) : pool[$urandom_range(0, 7)];
      do_req(we, a, 16'($urandom), acc);
      idle($urandom_range(0, 2));
    end

    idle(WAIT + 10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish by cyc %0d", cyc);
    $fatal(1);
  end

endmodule
